// File: rtl/keypad_entry_ctrl_if.sv
// Completed-entry handshake between the keypad sequencer and its consumer.
// The sequencer drives the master side, the application FSM the slave side.
interface keypad_entry_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] entry_value;
    logic [3:0]              entry_count;
    logic                    entry_valid;
    logic                    entry_ack;

    modport master (
        output entry_value,
        output entry_count,
        output entry_valid,
        input  entry_ack
    );

    modport slave (
        input  entry_value,
        input  entry_count,
        input  entry_valid,
        output entry_ack
    );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: one key per press/release, BCD edit buffer, Enter handshake.
// Optional idle discard of partial entries: define KEYPAD_ENTRY_TIMEOUT_EN.
module keypad_entry_ctrl #(
    parameter int          NUM_DIGITS     = 4,
    parameter int          RELEASE_CYCLES = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_500_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              key_code,
    input  logic                    key_pressed,
    output logic [4*NUM_DIGITS-1:0] buf_value,
    output logic [3:0]              buf_count,
    output logic                    key_event,
    output logic                    overflow,
    output logic                    timeout,
    keypad_entry_ctrl_if.master     ent
);
    localparam int W  = 4 * NUM_DIGITS;
    localparam int RW = (RELEASE_CYCLES < 2) ? 1 : $clog2(RELEASE_CYCLES);

    typedef enum logic [1:0] {IDLE, CAPTURE, RELEASE, DONE} state_t;

    state_t         state_q, state_d;
    logic [3:0]     code_q, code_d;
    logic [W-1:0]   buf_q, buf_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [W-1:0]   ent_val_q, ent_val_d;
    logic [3:0]     ent_cnt_q, ent_cnt_d;
    logic           valid_q, valid_d;
    logic           kev_q, kev_d;
    logic           ovf_q, ovf_d;
    logic [RW-1:0]  rel_q, rel_d;
    logic           to_fire;

    logic is_digit, is_bs, is_clr, is_ent;
    assign is_digit = (code_q <= 4'd9);
    assign is_bs    = (code_q == 4'd10);
    assign is_clr   = (code_q == 4'd11);
    assign is_ent   = (code_q == 4'd13);

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        ent_val_d = ent_val_q;
        ent_cnt_d = ent_cnt_q;
        valid_d   = valid_q;
        kev_d     = 1'b0;
        ovf_d     = 1'b0;
        rel_d     = rel_q;
        unique case (state_q)
            IDLE: begin
                if (key_pressed) begin
                    code_d  = key_code;
                    state_d = CAPTURE;
                end else if (to_fire) begin
                    buf_d = '0;
                    cnt_d = '0;
                end
            end
            CAPTURE: begin
                state_d = RELEASE;
                rel_d   = '0;
                unique case (1'b1)
                    is_digit: begin
                        if (cnt_q < 4'(NUM_DIGITS)) begin
                            buf_d = (buf_q << 4) | W'(code_q);
                            cnt_d = cnt_q + 4'd1;
                            kev_d = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    is_bs: begin
                        if (cnt_q != 4'd0) begin
                            buf_d = buf_q >> 4;
                            cnt_d = cnt_q - 4'd1;
                        end
                        kev_d = 1'b1;
                    end
                    is_clr: begin
                        buf_d = '0;
                        cnt_d = '0;
                        kev_d = 1'b1;
                    end
                    is_ent: begin
                        if (cnt_q != 4'd0) begin
                            ent_val_d = buf_q;
                            ent_cnt_d = cnt_q;
                            buf_d     = '0;
                            cnt_d     = '0;
                            valid_d   = 1'b1;
                            kev_d     = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            RELEASE: begin
                if (key_pressed) begin
                    rel_d = '0;
                end else if (rel_q == RW'(RELEASE_CYCLES - 1)) begin
                    rel_d   = '0;
                    state_d = valid_q ? DONE : IDLE;
                end else begin
                    rel_d = rel_q + 1'b1;
                end
            end
            DONE: begin
                if (valid_q && ent.entry_ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            code_q    <= '0;
            buf_q     <= '0;
            cnt_q     <= '0;
            ent_val_q <= '0;
            ent_cnt_q <= '0;
            valid_q   <= 1'b0;
            kev_q     <= 1'b0;
            ovf_q     <= 1'b0;
            rel_q     <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            ent_val_q <= ent_val_d;
            ent_cnt_q <= ent_cnt_d;
            valid_q   <= valid_d;
            kev_q     <= kev_d;
            ovf_q     <= ovf_d;
            rel_q     <= rel_d;
        end
    end

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    logic [23:0] to_q, to_d;
    logic        tout_q, tout_d;

    // A press in the same cycle wins; the timer restarts on leaving IDLE.
    always_comb begin
        to_d    = '0;
        to_fire = 1'b0;
        if (state_q == IDLE && !key_pressed && cnt_q != 4'd0 && !valid_q) begin
            if (to_q == TIMEOUT_CYCLES - 24'd1) begin
                to_fire = 1'b1;
            end else begin
                to_d = to_q + 24'd1;
            end
        end
        tout_d = to_fire;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_q   <= '0;
            tout_q <= 1'b0;
        end else begin
            to_q   <= to_d;
            tout_q <= tout_d;
        end
    end

    assign timeout = tout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign to_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    assign buf_value       = buf_q;
    assign buf_count       = cnt_q;
    assign key_event       = kev_q;
    assign overflow        = ovf_q;
    assign ent.entry_value = ent_val_q;
    assign ent.entry_count = ent_cnt_q;
    assign ent.entry_valid = valid_q;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl (NUM_DIGITS=4, RELEASE_CYCLES=4, TIMEOUT_CYCLES=16).
// Timeout scenario follows KEYPAD_ENTRY_TIMEOUT_EN.
module tb_keypad_entry_ctrl;
    localparam int ND = 4;
    localparam int RC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    key_code = 4'd0;
    logic          key_pressed = 1'b0;
    logic [4*ND-1:0] buf_value;
    logic [3:0]    buf_count;
    logic          key_event;
    logic          overflow;
    logic          timeout;

    int vec  = 0;
    int errs = 0;

    keypad_entry_ctrl_if #(.NUM_DIGITS(ND)) ent_if ();

    keypad_entry_ctrl #(
        .NUM_DIGITS    (ND),
        .RELEASE_CYCLES(RC),
        .TIMEOUT_CYCLES(24'd16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_code   (key_code),
        .key_pressed(key_pressed),
        .buf_value  (buf_value),
        .buf_count  (buf_count),
        .key_event  (key_event),
        .overflow   (overflow),
        .timeout    (timeout),
        .ent        (ent_if.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full press/release; returns the pulses seen right after CAPTURE.
    task automatic press(input logic [3:0] c, output logic ke, output logic ov);
        key_code    = c;
        key_pressed = 1'b1;
        tick();
        key_pressed = 1'b0;
        tick();
        ke = key_event;
        ov = overflow;
        repeat (RC) tick();
    endtask

    task automatic ack();
        ent_if.entry_ack = 1'b1;
        tick();
        ent_if.entry_ack = 1'b0;
    endtask

    task automatic test_reset();
        ent_if.entry_ack = 1'b0;
        #2;
        vec++;
        if ({buf_value, buf_count, key_event, overflow, timeout} !== '0) begin
            errs++;
            $display("FAIL reset_buf: got buf=%h cnt=%0d ke=%b ov=%b to=%b need 0",
                     buf_value, buf_count, key_event, overflow, timeout);
        end
        vec++;
        if ({ent_if.entry_value, ent_if.entry_count, ent_if.entry_valid} !== '0) begin
            errs++;
            $display("FAIL reset_entry: got val=%h cnt=%0d v=%b need 0",
                     ent_if.entry_value, ent_if.entry_count, ent_if.entry_valid);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_entry();
        logic ke, ov;
        logic [15:0] exp_buf [3];
        exp_buf[0] = 16'h0001;
        exp_buf[1] = 16'h0012;
        exp_buf[2] = 16'h0123;
        for (int i = 0; i < 3; i++) begin
            press(4'(i + 1), ke, ov);
            vec++;
            if (buf_value !== exp_buf[i] || buf_count !== 4'(i + 1) || ke !== 1'b1) begin
                errs++;
                $display("FAIL entry_step%0d: got buf=%h cnt=%0d ke=%b need %h %0d 1",
                         i, buf_value, buf_count, ke, exp_buf[i], i + 1);
            end
        end
        key_code = 4'd13;
        key_pressed = 1'b1;
        tick();
        key_pressed = 1'b0;
        tick();
        vec++;
        if (ent_if.entry_value !== 16'h0123 || ent_if.entry_count !== 4'd3 ||
            ent_if.entry_valid !== 1'b1 || key_event !== 1'b1) begin
            errs++;
            $display("FAIL entry_enter: got val=%h cnt=%0d v=%b ke=%b need 0123 3 1 1",
                     ent_if.entry_value, ent_if.entry_count, ent_if.entry_valid, key_event);
        end
        vec++;
        if (buf_value !== 16'h0 || buf_count !== 4'd0) begin
            errs++;
            $display("FAIL entry_bufclr: got buf=%h cnt=%0d need 0 0", buf_value, buf_count);
        end
        repeat (RC) tick();
        ack();
        vec++;
        if (ent_if.entry_valid !== 1'b0) begin
            errs++;
            $display("FAIL entry_ack: got v=%b need 0", ent_if.entry_valid);
        end
    endtask

    task automatic test_overflow();
        logic ke, ov;
        for (int i = 1; i <= 4; i++) press(4'(i), ke, ov);
        press(4'd5, ke, ov);
        vec++;
        if (ke !== 1'b0 || ov !== 1'b1 || buf_value !== 16'h1234 || buf_count !== 4'd4) begin
            errs++;
            $display("FAIL overflow: got ke=%b ov=%b buf=%h cnt=%0d need 0 1 1234 4",
                     ke, ov, buf_value, buf_count);
        end
        vec++;
        if (overflow !== 1'b0) begin
            errs++;
            $display("FAIL overflow_pulse: got ov=%b need 0 after pulse", overflow);
        end
        press(4'd11, ke, ov);
        vec++;
        if (ke !== 1'b1 || buf_value !== 16'h0 || buf_count !== 4'd0) begin
            errs++;
            $display("FAIL clear: got ke=%b buf=%h cnt=%0d need 1 0 0", ke, buf_value, buf_count);
        end
    endtask

    task automatic test_backspace();
        logic ke, ov;
        press(4'd7, ke, ov);
        press(4'd8, ke, ov);
        press(4'd10, ke, ov);
        vec++;
        if (ke !== 1'b1 || buf_value !== 16'h0007 || buf_count !== 4'd1) begin
            errs++;
            $display("FAIL backspace: got ke=%b buf=%h cnt=%0d need 1 0007 1",
                     ke, buf_value, buf_count);
        end
        press(4'd9, ke, ov);
        press(4'd13, ke, ov);
        vec++;
        if (ent_if.entry_value !== 16'h0079 || ent_if.entry_count !== 4'd2 ||
            ent_if.entry_valid !== 1'b1) begin
            errs++;
            $display("FAIL bs_entry: got val=%h cnt=%0d v=%b need 0079 2 1",
                     ent_if.entry_value, ent_if.entry_count, ent_if.entry_valid);
        end
        ack();
        press(4'd11, ke, ov);
        vec++;
        if (ke !== 1'b1 || buf_value !== 16'h0 || buf_count !== 4'd0) begin
            errs++;
            $display("FAIL clear_empty: got ke=%b buf=%h cnt=%0d need 1 0 0",
                     ke, buf_value, buf_count);
        end
        press(4'd10, ke, ov);
        vec++;
        if (ke !== 1'b1 || buf_count !== 4'd0) begin
            errs++;
            $display("FAIL bs_empty: got ke=%b cnt=%0d need 1 0", ke, buf_count);
        end
    endtask

    task automatic test_bounce();
        logic ke, ov;
        int   n;
        key_code = 4'd4;
        key_pressed = 1'b1;
        tick();
        tick();
        n = int'(key_event);
        for (int i = 0; i < RC - 1; i++) begin
            key_pressed = 1'b0;
            tick();
            n += int'(key_event);
        end
        key_pressed = 1'b1;
        tick();
        n += int'(key_event);
        key_pressed = 1'b0;
        for (int i = 0; i < RC + 4; i++) begin
            tick();
            n += int'(key_event);
        end
        vec++;
        if (n !== 1 || buf_value !== 16'h0004 || buf_count !== 4'd1) begin
            errs++;
            $display("FAIL bounce: got events=%0d buf=%h cnt=%0d need 1 0004 1",
                     n, buf_value, buf_count);
        end
        press(4'd11, ke, ov);
        press(4'd13, ke, ov);
        vec++;
        if (ke !== 1'b0 || ov !== 1'b0 || ent_if.entry_valid !== 1'b0) begin
            errs++;
            $display("FAIL enter_empty: got ke=%b ov=%b v=%b need 0 0 0",
                     ke, ov, ent_if.entry_valid);
        end
        press(4'd12, ke, ov);
        vec++;
        if (ke !== 1'b0 || buf_count !== 4'd0) begin
            errs++;
            $display("FAIL invalid_code: got ke=%b cnt=%0d need 0 0", ke, buf_count);
        end
    endtask

    task automatic test_done_ignore();
        logic ke, ov;
        press(4'd6, ke, ov);
        press(4'd13, ke, ov);
        press(4'd6, ke, ov);
        vec++;
        if (ke !== 1'b0 || buf_count !== 4'd0 || ent_if.entry_valid !== 1'b1 ||
            ent_if.entry_value !== 16'h0006) begin
            errs++;
            $display("FAIL done_ignore: got ke=%b cnt=%0d v=%b val=%h need 0 0 1 0006",
                     ke, buf_count, ent_if.entry_valid, ent_if.entry_value);
        end
        ent_if.entry_ack = 1'b1;
        #2;
        vec++;
        if (ent_if.entry_valid !== 1'b1) begin
            errs++;
            $display("FAIL ack_latency: got v=%b need 1 before edge", ent_if.entry_valid);
        end
        tick();
        ent_if.entry_ack = 1'b0;
        vec++;
        if (ent_if.entry_valid !== 1'b0 || buf_count !== 4'd0) begin
            errs++;
            $display("FAIL done_ack: got v=%b cnt=%0d need 0 0", ent_if.entry_valid, buf_count);
        end
        press(4'd2, ke, ov);
        vec++;
        if (ke !== 1'b1 || buf_value !== 16'h0002) begin
            errs++;
            $display("FAIL after_ack: got ke=%b buf=%h need 1 0002", ke, buf_value);
        end
        press(4'd11, ke, ov);
    endtask

    task automatic test_reset_mid();
        logic ke, ov;
        press(4'd1, ke, ov);
        press(4'd13, ke, ov);
        #2;
        rst = 1'b0;
        #1;
        vec++;
        if (ent_if.entry_valid !== 1'b0 || ent_if.entry_value !== 16'h0) begin
            errs++;
            $display("FAIL reset_pending: got v=%b val=%h need 0 0",
                     ent_if.entry_valid, ent_if.entry_value);
        end
        tick();
        rst = 1'b1;
        tick();
        press(4'd8, ke, ov);
        key_code = 4'd5;
        key_pressed = 1'b1;
        tick();
        key_pressed = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        vec++;
        if ({buf_value, buf_count, key_event, overflow, timeout,
             ent_if.entry_valid, ent_if.entry_count} !== '0) begin
            errs++;
            $display("FAIL reset_capture: got buf=%h cnt=%0d ke=%b v=%b need all 0",
                     buf_value, buf_count, key_event, ent_if.entry_valid);
        end
        tick();
        rst = 1'b1;
        tick();
        tick();
        vec++;
        if (buf_value !== 16'h0 || key_event !== 1'b0) begin
            errs++;
            $display("FAIL reset_no_capture: got buf=%h ke=%b need 0 0", buf_value, key_event);
        end
    endtask

    task automatic test_timeout();
        logic ke, ov;
        int   early;
        press(4'd3, ke, ov);
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
        early = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            early += int'(timeout);
        end
        vec++;
        if (early !== 0 || buf_count !== 4'd1) begin
            errs++;
            $display("FAIL timeout_early: got pulses=%0d cnt=%0d need 0 1", early, buf_count);
        end
        tick();
        vec++;
        if (timeout !== 1'b1 || buf_value !== 16'h0 || buf_count !== 4'd0) begin
            errs++;
            $display("FAIL timeout_fire: got to=%b buf=%h cnt=%0d need 1 0 0",
                     timeout, buf_value, buf_count);
        end
        tick();
        vec++;
        if (timeout !== 1'b0) begin
            errs++;
            $display("FAIL timeout_pulse: got to=%b need 0", timeout);
        end
`else
        early = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            early += int'(timeout);
        end
        vec++;
        if (early !== 0 || buf_value !== 16'h0003 || buf_count !== 4'd1) begin
            errs++;
            $display("FAIL persist: got pulses=%0d buf=%h cnt=%0d need 0 0003 1",
                     early, buf_value, buf_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_entry();
        test_overflow();
        test_backspace();
        test_bounce();
        test_done_ignore();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Sequencer that sits downstream of the keypad scan/encoder path and turns the stream of encoded keys into complete multi-digit BCD entries. It accepts one key per press–release cycle and maintains an edit buffer with backspace and clear. On Enter it presents the finished entry to the application FSM with a valid/ack handshake. It owns all key-acceptance policy, so upstream blocks only scan and encode.

## Interface
Parameters:
- NUM_DIGITS, 4: maximum digits per entry (1–8).
- RELEASE_CYCLES, 4: consecutive cycles with key_pressed low required to re-arm.
- TIMEOUT_CYCLES, 24'd12_500_000: idle cycles before a partial entry is discarded (only with timeout feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- key_code  in  4  encoded key: 0–9 digit, 10 backspace, 11 clear, 13 Enter, others invalid.
- key_pressed  in  1  debounced press level from encoder path.
- entry_ack  in  1  consumer accepts entry_value.
- buf_value  out  4*NUM_DIGITS  live edit buffer, BCD, newest digit in [3:0].
- buf_count  out  4  digits currently in buffer.
- entry_value  out  4*NUM_DIGITS  latched completed entry.
- entry_count  out  4  digit count of entry_value.
- entry_valid  out  1  completed entry pending.
- key_event  out  1  one-cycle pulse per accepted key.
- overflow  out  1  one-cycle pulse when a digit is rejected because buffer is full.
- timeout  out  1  one-cycle pulse when the buffer is discarded by timeout; tied 0 without the feature.

## Operation
- States: IDLE, CAPTURE, RELEASE, DONE. Reset state is IDLE.
- IDLE: on key_pressed=1, register key_code and go to CAPTURE.
- CAPTURE (one cycle): act on the registered code, then go to RELEASE. DONE is entered only via Enter (see below).
  - Digit with buf_count<NUM_DIGITS: shift the buffer left 4 bits, insert the digit, increment buf_count, pulse key_event.
  - Digit with buffer full: buffer unchanged, pulse overflow, no key_event.
  - Backspace (10): shift the buffer right 4 bits with zero fill, decrement buf_count. With buf_count=0 it is a no-op. key_event pulses in both cases.
  - Clear (11): zero the buffer and buf_count, pulse key_event.
  - Enter (13) with buf_count>0: copy the buffer to entry_value/entry_count, zero the buffer, set entry_valid, pulse key_event, go to RELEASE then DONE.
  - Enter with buf_count=0: ignored, no pulse.
  - Invalid codes: ignored, no pulse, still go to RELEASE.
- RELEASE: count consecutive cycles with key_pressed=0. Any cycle with key_pressed=1 resets the count. At RELEASE_CYCLES, go to IDLE, or to DONE if entry_valid=1.
- DONE: key presses are ignored. When entry_valid=1 and entry_ack=1, clear entry_valid and go to IDLE.
- entry_ack while entry_valid=0 has no effect.
- A key still held on entering DONE cannot be captured after ack, because RELEASE has already completed before DONE is entered.

## Timing
- Reset values: all outputs 0, state IDLE, release counter 0, timeout counter 0.
- Press sampled high in IDLE at cycle n gives CAPTURE at n+1. Buffer, buf_count and the key_event/overflow pulses update at the n+2 edge, visible in cycle n+2.
- entry_valid rises in the same cycle the buffer clears (n+2).
- entry_valid falls the cycle after the edge that samples entry_ack=1.
- Minimum spacing between accepted keys: 2 + RELEASE_CYCLES cycles.
- Assertion of rst mid-operation immediately clears everything, including a pending entry_valid.
- key_code is sampled only in IDLE; changes during RELEASE or DONE are ignored.

## Configuration
- Macro KEYPAD_ENTRY_TIMEOUT_EN.
- When defined, a counter runs while the state is IDLE and buf_count>0. It clears on any transition out of IDLE.
- When the counter reaches TIMEOUT_CYCLES-1, the buffer and buf_count clear and timeout pulses for one cycle.
- No timeout occurs while entry_valid=1.
- When undefined: no counter is built, timeout is constant 0, and the buffer persists indefinitely.

## Test plan
- Reset, press 1, 2, 3, each with ≥RELEASE_CYCLES release, then Enter -> buf_value 0x123 steps visible. Then entry_value=0x0123, entry_count=3, entry_valid=1, buf_count=0.
- Press 5 digits with NUM_DIGITS=4 -> fifth press pulses overflow once with no key_event, and buf_value keeps the first four digits.
- Enter 7, 8, backspace, 9, Enter -> entry_value=0x0079. Clear on an empty buffer -> key_event pulses and the buffer stays 0.
- Hold 4 with key_pressed bouncing low for RELEASE_CYCLES-1 cycles, then high -> exactly one key_event. Enter with an empty buffer -> no pulse.
- With entry_valid=1, press 6, then assert entry_ack -> 6 ignored, entry_valid drops next cycle, and buf_count stays 0. Assert rst low mid-CAPTURE -> all outputs 0 immediately.
- With KEYPAD_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=16: enter 3, then idle -> timeout pulses 16 cycles after the return to IDLE and the buffer clears. Repeat without the macro -> the buffer persists.
